// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg
//   Shared definitions for the VGA scan-out back-end:
//     - default 640x480@60 timing constants and derived totals / sync windows
//     - rgb565_t / rgb888_t pixel structs and the 5:6:5 -> 8:8:8 expander
//     - timing_t bundle (active, hs_n, vs_n) carried through the delay line
package vga_timing_pkg;

    localparam int unsigned H_ACTIVE_DEF = 640;
    localparam int unsigned H_FP_DEF     = 16;
    localparam int unsigned H_SYNC_DEF   = 96;
    localparam int unsigned H_BP_DEF     = 48;
    localparam int unsigned V_ACTIVE_DEF = 480;
    localparam int unsigned V_FP_DEF     = 10;
    localparam int unsigned V_SYNC_DEF   = 2;
    localparam int unsigned V_BP_DEF     = 33;
    localparam int unsigned CLK_DIV_DEF  = 2;
    localparam int unsigned DATA_LAT_DEF = 0;

    localparam int unsigned H_TOTAL_DEF   = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF   = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int unsigned HS_START_DEF  = H_ACTIVE_DEF + H_FP_DEF;
    localparam int unsigned HS_END_DEF    = HS_START_DEF + H_SYNC_DEF;
    localparam int unsigned VS_START_DEF  = V_ACTIVE_DEF + V_FP_DEF;
    localparam int unsigned VS_END_DEF    = VS_START_DEF + V_SYNC_DEF;

    typedef struct packed {
        logic [4:0] r5;
        logic [5:0] g6;
        logic [4:0] b5;
    } rgb565_t;

    typedef struct packed {
        logic [7:0] r8;
        logic [7:0] g8;
        logic [7:0] b8;
    } rgb888_t;

    typedef struct packed {
        logic active;
        logic hs_n;
        logic vs_n;
    } timing_t;

    // Blank with both syncs deasserted (active-low, so high).
    localparam timing_t TIMING_IDLE = '{active: 1'b0, hs_n: 1'b1, vs_n: 1'b1};

    // Replicate the MSBs into the new LSBs so full scale maps to 8'hFF.
    function automatic rgb888_t expand565(input rgb565_t p);
        rgb888_t o;
        o.r8 = {p.r5, p.r5[4:2]};
        o.g8 = {p.g6, p.g6[5:4]};
        o.b8 = {p.b5, p.b5[4:2]};
        return o;
    endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// vga_sync_counter
//   Pixel-clock divider and raster counters.
//   Ports:
//     clk_i, rst_i    system clock, asynchronous active-high reset
//     sys_x_o/sys_y_o registered raster coordinates
//     pix_tick_o      one-clk pulse in the last divider cycle of each pixel
//     frame_start_o   pulse on the tick that wraps the counters to (0,0)
//     vblank_o        registered, high while sys_y_o >= V_ACTIVE
//     vga_clk_o       registered pixel clock, high in second half of pixel
//     raw_o           undelayed active/hs_n/vs_n decoded from the counters
module vga_sync_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [9:0] sys_x_o,
    output logic [9:0] sys_y_o,
    output logic       pix_tick_o,
    output logic       frame_start_o,
    output logic       vblank_o,
    output logic       vga_clk_o,
    output timing_t    raw_o
);

    localparam int unsigned DIV_W = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);

    localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_BEG = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_BEG = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_ACTIVE + V_FP + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       x_q, x_d;
    logic [9:0]       y_q, y_d;
    logic             vblank_q;
    logic             vga_clk_q;
    logic             tick;

    always_comb begin
        tick  = (div_q == DIV_LAST);
        div_d = tick ? '0 : div_q + DIV_W'(1);
        x_d   = x_q;
        y_d   = y_q;
        if (tick) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                y_d = (y_q == V_LAST) ? '0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    // vblank and vga_clk are computed from next-state values so they are
    // registered yet stay aligned with the counters they describe.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q     <= '0;
            x_q       <= '0;
            y_q       <= '0;
            vblank_q  <= 1'b0;
            vga_clk_q <= 1'b0;
        end else begin
            div_q     <= div_d;
            x_q       <= x_d;
            y_q       <= y_d;
            vblank_q  <= (y_d >= V_ACT);
            vga_clk_q <= (div_d >= DIV_HALF);
        end
    end

    assign sys_x_o       = x_q;
    assign sys_y_o       = y_q;
    assign pix_tick_o    = tick;
    assign frame_start_o = tick && (x_q == H_LAST) && (y_q == V_LAST);
    assign vblank_o      = vblank_q;
    assign vga_clk_o     = vga_clk_q;

    always_comb begin
        raw_o        = TIMING_IDLE;
        raw_o.active = (x_q < H_ACT) && (y_q < V_ACT);
        raw_o.hs_n   = !((x_q >= HS_BEG) && (x_q < HS_END));
        raw_o.vs_n   = !((y_q >= VS_BEG) && (y_q < VS_END));
    end

endmodule

// File: rtl/vga_scan_output.sv
// vga_scan_output
//   VGA back-end: generates SYS_X/SYS_Y for the graphic register chain,
//   samples the returned RGB565 pixel, expands it to 8:8:8 and drives
//   delay-matched VGA syncs/blank.
//   Ports:
//     CLK, RST               system clock, asynchronous active-high reset
//     CURRENT_GRAPHIC_DATA   RGB565 pixel, valid DATA_LAT ticks after coords
//     SYS_X, SYS_Y           registered raster coordinates
//     PIX_TICK, FRAME_START  pixel-advance and frame-wrap pulses
//     VBLANK                 high while SYS_Y >= V_ACTIVE
//     VGA_CLK                registered pixel clock
//     VGA_R/G/B              expanded colour, zero outside visible area
//     VGA_HS, VGA_VS         active-low syncs
//     VGA_BLANK_N            high during a visible output pixel
//     VGA_SYNC_N             tied low
module vga_scan_output
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
    parameter int unsigned H_FP     = H_FP_DEF,
    parameter int unsigned H_SYNC   = H_SYNC_DEF,
    parameter int unsigned H_BP     = H_BP_DEF,
    parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
    parameter int unsigned V_FP     = V_FP_DEF,
    parameter int unsigned V_SYNC   = V_SYNC_DEF,
    parameter int unsigned V_BP     = V_BP_DEF,
    parameter int unsigned CLK_DIV  = CLK_DIV_DEF,
    parameter int unsigned DATA_LAT = DATA_LAT_DEF
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [15:0] CURRENT_GRAPHIC_DATA,
    output logic [9:0]  SYS_X,
    output logic [9:0]  SYS_Y,
    output logic        PIX_TICK,
    output logic        VBLANK,
    output logic        FRAME_START,
    output logic        VGA_CLK,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic        VGA_SYNC_N
);

    logic    pix_tick;
    timing_t raw;

    vga_sync_counter #(
        .H_ACTIVE (H_ACTIVE),
        .H_FP     (H_FP),
        .H_SYNC   (H_SYNC),
        .H_BP     (H_BP),
        .V_ACTIVE (V_ACTIVE),
        .V_FP     (V_FP),
        .V_SYNC   (V_SYNC),
        .V_BP     (V_BP),
        .CLK_DIV  (CLK_DIV)
    ) u_sync (
        .clk_i         (CLK),
        .rst_i         (RST),
        .sys_x_o       (SYS_X),
        .sys_y_o       (SYS_Y),
        .pix_tick_o    (pix_tick),
        .frame_start_o (FRAME_START),
        .vblank_o      (VBLANK),
        .vga_clk_o     (VGA_CLK),
        .raw_o         (raw)
    );

    assign PIX_TICK = pix_tick;

    // stage_d[i] is what stage i loads on the next tick. stage_d[DATA_LAT]
    // is the timing of the pixel whose data is on CURRENT_GRAPHIC_DATA now,
    // so colour and stage_q[DATA_LAT] update together on the same tick.
    timing_t stage_q [DATA_LAT+1];
    timing_t stage_d [DATA_LAT+1];
    rgb888_t rgb_q, rgb_d;

    always_comb begin
        stage_d[0] = raw;
        for (int unsigned i = 1; i <= DATA_LAT; i++) begin
            stage_d[i] = stage_q[i-1];
        end
        rgb_d = stage_d[DATA_LAT].active ? expand565(rgb565_t'(CURRENT_GRAPHIC_DATA)) : '0;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned i = 0; i <= DATA_LAT; i++) begin
                stage_q[i] <= TIMING_IDLE;
            end
            rgb_q <= '0;
        end else if (pix_tick) begin
            for (int unsigned i = 0; i <= DATA_LAT; i++) begin
                stage_q[i] <= stage_d[i];
            end
            rgb_q <= rgb_d;
        end
    end

    assign VGA_R       = rgb_q.r8;
    assign VGA_G       = rgb_q.g8;
    assign VGA_B       = rgb_q.b8;
    assign VGA_HS      = stage_q[DATA_LAT].hs_n;
    assign VGA_VS      = stage_q[DATA_LAT].vs_n;
    assign VGA_BLANK_N = stage_q[DATA_LAT].active;
    assign VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_scan_output.sv
module tb_vga_scan_output;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // u0: default timing, DATA_LAT=0, CLK_DIV=2
    logic [15:0] D0;
    logic [9:0]  X0, Y0;
    logic        T0, VB0, FS0, VC0, HS0, VS0, BN0, SN0;
    logic [7:0]  R0, G0, B0;
    // u1: small timing (15x11), DATA_LAT=2, CLK_DIV=2
    logic [15:0] D1;
    logic [9:0]  X1, Y1;
    logic        T1, VB1, FS1, VC1, HS1, VS1, BN1, SN1;
    logic [7:0]  R1, G1, B1;
    // u2: small timing, DATA_LAT=0, CLK_DIV=4
    logic [15:0] D2;
    logic [9:0]  X2, Y2;
    logic        T2, VB2, FS2, VC2, HS2, VS2, BN2, SN2;
    logic [7:0]  R2, G2, B2;

    vga_scan_output u0 (
        .CLK(CLK), .RST(RST), .CURRENT_GRAPHIC_DATA(D0), .SYS_X(X0), .SYS_Y(Y0),
        .PIX_TICK(T0), .VBLANK(VB0), .FRAME_START(FS0), .VGA_CLK(VC0),
        .VGA_R(R0), .VGA_G(G0), .VGA_B(B0), .VGA_HS(HS0), .VGA_VS(VS0),
        .VGA_BLANK_N(BN0), .VGA_SYNC_N(SN0));

    vga_scan_output #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(2), .DATA_LAT(2)
    ) u1 (
        .CLK(CLK), .RST(RST), .CURRENT_GRAPHIC_DATA(D1), .SYS_X(X1), .SYS_Y(Y1),
        .PIX_TICK(T1), .VBLANK(VB1), .FRAME_START(FS1), .VGA_CLK(VC1),
        .VGA_R(R1), .VGA_G(G1), .VGA_B(B1), .VGA_HS(HS1), .VGA_VS(VS1),
        .VGA_BLANK_N(BN1), .VGA_SYNC_N(SN1));

    vga_scan_output #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
        .CLK_DIV(4), .DATA_LAT(0)
    ) u2 (
        .CLK(CLK), .RST(RST), .CURRENT_GRAPHIC_DATA(D2), .SYS_X(X2), .SYS_Y(Y2),
        .PIX_TICK(T2), .VBLANK(VB2), .FRAME_START(FS2), .VGA_CLK(VC2),
        .VGA_R(R2), .VGA_G(G2), .VGA_B(B2), .VGA_HS(HS2), .VGA_VS(VS2),
        .VGA_BLANK_N(BN2), .VGA_SYNC_N(SN2));

    // Memory models: u0 returns data in the same pixel, u1 two ticks later.
    always_comb D0 = (X0 == 10'd10) ? 16'hF800 : 16'h001F;

    function automatic logic [15:0] f1(input logic [9:0] x);
        if (x >= 10'd7) return 16'hFFFF;
        return 16'h0841 * 16'(x + 10'd1);
    endfunction

    logic [15:0] d1_a, d1_b;
    always @(posedge CLK) begin
        if (T1) begin
            d1_a <= f1(X1);
            d1_b <= d1_a;
        end
    end
    assign D1 = d1_b;
    initial D2 = 16'h0000;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: timed out waiting for DUT event", name);
    endtask

    // Scoreboard entry: output pixel tag and expected {rgb24, hs, vs, blank_n}
    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [26:0] exp;
    } sb_t;
    sb_t q0[$];
    sb_t q1[$];

    task automatic push(input int which, input int x, input int y, input logic [23:0] rgb,
                        input logic hs, input logic vs, input logic bn);
        sb_t e;
        e.x   = 10'(x);
        e.y   = 10'(y);
        e.exp = {rgb, hs, vs, bn};
        if (which == 0) q0.push_back(e);
        else q1.push_back(e);
    endtask

    // Monitor u0: the pixel shown after a tick is the coordinate present at it.
    initial begin : mon0
        logic [9:0] px, py;
        bit pend;
        sb_t e;
        pend = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                pend = 0;
            end else begin
                if (pend) begin
                    pend = 0;
                    if (q0.size() > 0 && q0[0].x == px && q0[0].y == py) begin
                        e = q0.pop_front();
                        chk($sformatf("u0_pix_x%0d_y%0d", px, py),
                            64'({R0, G0, B0, HS0, VS0, BN0}), 64'(e.exp));
                    end
                end
                if (T0) begin
                    px = X0;
                    py = Y0;
                    pend = 1;
                end
            end
        end
    end

    // Monitor u1: output after a tick belongs to the coordinate two ticks older.
    initial begin : mon1
        logic [9:0] hx [3];
        logic [9:0] hy [3];
        logic [9:0] px, py;
        int nv;
        bit pend;
        sb_t e;
        pend = 0;
        nv = 0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                pend = 0;
                nv = 0;
            end else begin
                if (pend) begin
                    pend = 0;
                    if (q1.size() > 0 && q1[0].x == px && q1[0].y == py) begin
                        e = q1.pop_front();
                        chk($sformatf("u1_pix_x%0d_y%0d", px, py),
                            64'({R1, G1, B1, HS1, VS1, BN1}), 64'(e.exp));
                    end
                end
                if (T1) begin
                    hx[2] = hx[1]; hx[1] = hx[0]; hx[0] = X1;
                    hy[2] = hy[1]; hy[1] = hy[0]; hy[0] = Y1;
                    if (nv < 3) nv++;
                    if (nv == 3) begin
                        px = hx[2];
                        py = hy[2];
                        pend = 1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit          found;
        logic [39:0] tb0, tv0, tb2, tv2;
        int          cnt, lat, vs_low, vb_high;
        bit          lat_done, vb_prev;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        #1 RST = 1'b0;

        // Reset mid-line at SYS_X=300
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (X0 == 10'd300) begin found = 1; break; end
        end
        if (!found) timeout_fail("wait_x300");
        chk("pre_reset_blank_n", 64'(BN0), 64'd1);
        #1 RST = 1'b1;
        #1;
        chk("rst_sys_x", 64'(X0), 64'd0);
        chk("rst_sys_y", 64'(Y0), 64'd0);
        chk("rst_hs", 64'(HS0), 64'd1);
        chk("rst_vs", 64'(VS0), 64'd1);
        chk("rst_blank_n", 64'(BN0), 64'd0);
        chk("rst_rgb", 64'({R0, G0, B0}), 64'd0);
        chk("rst_pix_tick", 64'(T0), 64'd0);
        chk("rst_vga_clk", 64'(VC0), 64'd0);
        chk("rst_vblank", 64'(VB0), 64'd0);
        chk("rst_frame_start", 64'(FS0), 64'd0);
        chk("sync_n", 64'(SN0), 64'd0);
        @(negedge CLK);
        #1 RST = 1'b0;

        // Expected output pixels, in raster order per instance
        push(0,  10, 0, 24'hFF0000, 1, 1, 1);
        push(0,  11, 0, 24'h0000FF, 1, 1, 1);
        push(0, 639, 0, 24'h0000FF, 1, 1, 1);
        push(0, 640, 0, 24'h000000, 1, 1, 0);
        push(0, 655, 0, 24'h000000, 1, 1, 0);
        push(0, 656, 0, 24'h000000, 0, 1, 0);
        push(0, 751, 0, 24'h000000, 0, 1, 0);
        push(0, 752, 0, 24'h000000, 1, 1, 0);
        push(0,   9, 1, 24'h0000FF, 1, 1, 1);
        push(0,  10, 1, 24'hFF0000, 1, 1, 1);
        push(1,   0, 0, 24'h080808, 1, 1, 1);
        push(1,   3, 0, 24'h212021, 1, 1, 1);
        push(1,   7, 0, 24'hFFFFFF, 1, 1, 1);
        push(1,   8, 0, 24'h000000, 1, 1, 0);
        push(1,  10, 0, 24'h000000, 0, 1, 0);
        push(1,   0, 1, 24'h080808, 1, 1, 1);
        push(1,   0, 7, 24'h000000, 1, 0, 0);
        push(1,  14, 8, 24'h000000, 1, 0, 0);
        push(1,   0, 9, 24'h000000, 1, 1, 0);

        // Divider patterns over the first 40 CLK after release
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            tb0[k-1] = T0; tv0[k-1] = VC0;
            tb2[k-1] = T2; tv2[k-1] = VC2;
            if (k == 2) chk("first_tick_x", 64'(X0), 64'd1);
        end
        chk("div2_pix_tick", 64'(tb0), 64'h55_5555_5555);
        chk("div2_vga_clk", 64'(tv0), 64'h55_5555_5555);
        chk("div4_pix_tick", 64'(tb2), 64'h44_4444_4444);
        chk("div4_vga_clk", 64'(tv2), 64'h66_6666_6666);
        chk("div4_sys_x", 64'(X2), 64'd10);
        chk("div2_sys_x", 64'(X0), 64'd20);

        // HS low width on line 0
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (!HS0) begin found = 1; break; end
        end
        if (!found) timeout_fail("wait_hs_low");
        cnt = 0;
        while (!HS0 && cnt < 400) begin
            cnt++;
            @(negedge CLK);
        end
        chk("hs_low_clk", 64'(cnt), 64'd192);

        // Line wrap 799 -> 0
        found = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge CLK);
            if (T0 && X0 == 10'd799) begin found = 1; break; end
        end
        if (!found) timeout_fail("wait_x799");
        @(negedge CLK);
        chk("wrap_sys_x", 64'(X0), 64'd0);
        chk("wrap_sys_y", 64'(Y0), 64'd1);

        // Visible run on line 1
        found = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (BN0) begin found = 1; break; end
        end
        if (!found) timeout_fail("wait_blank_n");
        cnt = 0;
        while (BN0 && cnt < 3000) begin
            cnt++;
            @(negedge CLK);
        end
        chk("blank_n_high_clk", 64'(cnt), 64'd1280);

        // One full frame of u1: period, latency, VS width, VBLANK window
        found = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge CLK);
            if (FS1) begin found = 1; break; end
        end
        if (!found) timeout_fail("wait_frame_start");
        cnt = 0; lat = 0; lat_done = 0; vs_low = 0; vb_high = 0;
        vb_prev = VB1;
        found = 0;
        while (cnt < 2000) begin
            @(negedge CLK);
            cnt++;
            if (!lat_done) begin
                if (BN1) lat_done = 1;
                else if (T1) lat++;
            end
            if (!VS1) vs_low++;
            if (VB1) vb_high++;
            if (VB1 && !vb_prev) begin
                chk("vblank_rise_y", 64'(Y1), 64'd6);
                chk("vblank_rise_x", 64'(X1), 64'd0);
            end
            vb_prev = VB1;
            if (FS1) begin found = 1; break; end
        end
        if (!found) timeout_fail("wait_frame_start_2");
        chk("frame_period_clk", 64'(cnt), 64'd330);
        chk("first_visible_latency", 64'(lat), 64'd3);
        chk("vs_low_clk", 64'(vs_low), 64'd60);
        chk("vblank_high_clk", 64'(vb_high), 64'd150);

        // Drain scoreboards
        for (int i = 0; i < 5000; i++) begin
            if (q0.size() == 0 && q1.size() == 0) break;
            @(negedge CLK);
        end
        while (q0.size() > 0) begin
            timeout_fail($sformatf("u0_pix_x%0d_y%0d_never_seen", q0[0].x, q0[0].y));
            void'(q0.pop_front());
        end
        while (q1.size() > 0) begin
            timeout_fail($sformatf("u1_pix_x%0d_y%0d_never_seen", q1[0].x, q1[0].y));
            void'(q1.pop_front());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_scan_output.md
Name: vga_scan_output

Overview:
- Display back-end directly downstream of the graphic instruction memory chain.
- Generates the raster scan coordinates SYS_X/SYS_Y. These feed the 64-entry graphic register chain.
- Samples the resolved 16-bit RGB565 pixel (CURRENT_GRAPHIC_DATA) back from that chain and expands it to 8:8:8.
- Drives VGA sync and blank signals, all delay-matched so colour and syncs leave on the same pixel.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, CLK cycles per pixel (>=2)
- DATA_LAT, 0, pixel ticks from SYS_X/SYS_Y change until CURRENT_GRAPHIC_DATA is valid (0..4)

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-high reset
- CURRENT_GRAPHIC_DATA  in  16  RGB565 pixel from graphic register chain (R[15:11] G[10:5] B[4:0])
- SYS_X  out  10  current horizontal count (registered)
- SYS_Y  out  10  current vertical count (registered)
- PIX_TICK  out  1  one-CLK pulse marking each pixel advance
- VBLANK  out  1  high while SYS_Y >= V_ACTIVE (safe window for instruction writes)
- FRAME_START  out  1  one-CLK pulse on the tick where counters go to (0,0)
- VGA_CLK  out  1  pixel clock, registered, high for second half of each pixel period
- VGA_R, VGA_G, VGA_B  out  8 each  expanded colour
- VGA_HS, VGA_VS  out  1 each  active-low syncs
- VGA_BLANK_N  out  1  high during visible output pixel
- VGA_SYNC_N  out  1  constant 0

Behaviour:
- Clock and reset: one clock CLK. RST is asynchronous and active-high; all flops clear on RST assertion regardless of CLK.
- Reset values:
  - div counter 0; SYS_X=0, SYS_Y=0
  - PIX_TICK, FRAME_START, VGA_CLK = 0; VBLANK = 0
  - VGA_HS=1, VGA_VS=1, VGA_BLANK_N=0; RGB=0
  - all delay-line stages = inactive (blank, syncs high)
- Divider:
  - div counts 0..CLK_DIV-1, then wraps.
  - PIX_TICK=1 in the CLK cycle where div==CLK_DIV-1.
  - VGA_CLK=1 when div >= CLK_DIV/2.
- Counters, advancing on tick only (H_TOTAL=800, V_TOTAL=525 at defaults):
  - SYS_X increments, wrapping H_TOTAL-1 -> 0.
  - On that wrap, SYS_Y increments, wrapping V_TOTAL-1 -> 0.
  - FRAME_START pulses on the tick where both wrap.
- Raw timing, combinational from the counters:
  - active = SYS_X<H_ACTIVE && SYS_Y<V_ACTIVE
  - hs_n low for SYS_X in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
  - vs_n low for SYS_Y in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
  - VBLANK = (SYS_Y>=V_ACTIVE), registered alongside SYS_Y.
- Alignment:
  - active, hs_n, vs_n pass through a (DATA_LAT+1)-stage tick-enabled shift register.
  - On each tick, the output colour register loads expand(CURRENT_GRAPHIC_DATA) if active delayed by DATA_LAT is 1, else 0.
  - Colour, VGA_HS, VGA_VS, VGA_BLANK_N therefore change together, DATA_LAT+1 ticks after the coordinates.
  - Outputs hold between ticks.
- Expansion: R8={R5,R5[4:2]}, G8={G6,G6[5:4]}, B8={B5,B5[4:2]}. 16'hFFFF -> FF/FF/FF; 16'h0000 -> 00/00/00.
- Blanking: RGB is forced to 0 whenever VGA_BLANK_N=0, regardless of input.
- Reset mid-frame: counters and pipeline clear immediately. The first tick after release advances to SYS_X=1. No partial sync pulse persists.
- No back-pressure: the block free-runs and the upstream must meet DATA_LAT.

Decomposition:
- Package vga_timing_pkg:
  - default timing constants and derived H_TOTAL/V_TOTAL and sync start/end
  - packed struct rgb565_t (r5,g6,b5)
  - function expand565
- Sub-module vga_sync_counter: divider plus SYS_X/SYS_Y counters, PIX_TICK, FRAME_START, raw active/hs_n/vs_n.
- Top module holds the delay line and colour register.

Test Plan:
- Reset:
  - Stimulus: assert RST mid-line (SYS_X=300), release.
  - Required: immediately SYS_X=0, SYS_Y=0, VGA_HS=VGA_VS=1, BLANK_N=0, RGB=0. The first tick after release gives SYS_X=1.
- Line timing, defaults:
  - SYS_X wraps 799->0 and SYS_Y increments.
  - VGA_HS low for exactly 96 ticks (192 CLK); first low output pixel corresponds to SYS_X=656.
  - BLANK_N high for 640 consecutive ticks per visible line.
- Frame timing:
  - FRAME_START period = 840000 CLK.
  - VGA_VS low for 2 lines, SYS_Y 490..491.
  - VBLANK high for SYS_Y 480..524.
- Colour path, DATA_LAT=0:
  - Stimulus: drive CURRENT_GRAPHIC_DATA=16'hF800 when SYS_X==10, else 16'h001F.
  - Required: output pixel 10 = R=FF,G=00,B=00; neighbours R=00,G=00,B=FF; syncs aligned.
- Latency, DATA_LAT=2:
  - Stimulus: model returns data 2 ticks after coordinates.
  - Required: pixel (0,0) is the first non-blank output, exactly 3 ticks after SYS_X=0,SYS_Y=0.
  - Required: last visible pixel 639 is followed by blank with RGB=0 even though input stays 16'hFFFF.
- Divider, CLK_DIV=4:
  - PIX_TICK every 4 CLK.
  - VGA_CLK high 2 of every 4 CLK.
  - Counters advance once per 4 CLK.
